countdown_timer: RTL
====================

Name: countdown_timer

Overview:
BCD countdown timer, the counterpart of the stopwatch: it counts down in 0.01 s ticks instead of up.
- Takes a 4-digit BCD preset (max 99.99 s) and decrements it to 00.00.
- Signals expiry with a one-cycle done pulse and a sticky expired flag.
- Sits beside the stopwatch in the timing subsystem and drives the same 4-digit display path.

Parameters:
CLK_PER_TICK, 100000, clk cycles per 0.01 s tick (100000 @ 10 MHz); must be >= 2
PRESET_W, 16, preset/count width (4 BCD digits, fixed at 16)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
load  input  1  capture preset into count (level sampled each cycle)
start  input  1  begin/resume countdown
stop  input  1  pause countdown; in EXPIRED, acknowledge and clear
preset  input  16  BCD preset {tens_s, units_s, tenths, hundredths}
count_bcd  output  16  current remaining time, BCD
running  output  1  high while state == RUNNING
expired  output  1  high while state == EXPIRED
done_pulse  output  1  one-cycle pulse on the cycle count_bcd first shows 0000 from a decrement

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, count_bcd=16'h0000, prescaler=0.
  - running=0, expired=0, done_pulse=0.
  - rst overrides all other inputs.
- States: IDLE, LOADED, RUNNING, PAUSED, EXPIRED.
- Command priority when several are high in one cycle: load > stop > start.
- load (any state):
  - count_bcd <= sanitized preset; prescaler <= 0.
  - state <= LOADED if sanitized preset != 0, else IDLE.
  - Sanitize: any digit > 9 saturates to 9 (e.g. 16'h1A5F -> 16'h1959).
- start:
  - LOADED or PAUSED -> RUNNING; prescaler <= 0 when leaving LOADED, prescaler held when leaving PAUSED.
  - Ignored in IDLE, RUNNING and EXPIRED.
- stop:
  - RUNNING -> PAUSED; count and prescaler freeze.
  - EXPIRED -> IDLE; count stays 0000.
  - Ignored elsewhere.
- RUNNING:
  - Prescaler counts 0..CLK_PER_TICK-1 and wraps.
  - On the cycle the prescaler equals CLK_PER_TICK-1, a tick decrements count_bcd by one hundredth.
  - BCD borrow chain: digit 0 -> 9 with a borrow into the next digit (e.g. 0100 -> 0099, 1000 -> 0999).
  - Decrement never wraps below 0000.
- Expiry:
  - A tick that takes count 0001 -> 0000 sets state <= EXPIRED.
  - done_pulse=1 for exactly that one register cycle.
  - The next cycle shows expired=1, running=0.
- EXPIRED holds count 0000 until load, stop or rst. done_pulse does not re-fire.
- Outputs are registered. running, expired and done_pulse are state-decoded from registered state, with zero combinational paths from inputs.
- Latency:
  - A command sampled at posedge N is visible on the outputs after posedge N.
  - First decrement after start from LOADED: CLK_PER_TICK cycles later.
- Reset mid-countdown: immediately returns to IDLE/0000, and a pending tick is discarded.
- load while RUNNING: reloads and goes to LOADED. The countdown halts and needs a fresh start.

Decomposition:
- Package countdown_pkg:
  - State encoding constants: IDLE=0, LOADED=1, RUNNING=2, PAUSED=3, EXPIRED=4, 3-bit.
  - BCD_MAX_DIGIT=4'd9.
  - Function for digit sanitization.
- Sub-module bcd_digit_down:
  - One decade down-counter with inputs dec_en, load, load_val[3:0] and outputs q[3:0], borrow_out.
  - borrow_out = dec_en & (q==0).
  - Instantiated 4 times in a chain.
- Top: FSM, prescaler, expiry detect (all digits 0 except hundredths==1 with tick).

Test Plan (CLK_PER_TICK=4 for simulation):
1. Reset: rst=1 for 2 cycles with load/start toggling -> count_bcd=0000, running=0, expired=0, done_pulse=0 throughout.
2. Borrow chain: load preset 16'h1000, start -> first tick at cycle 4 gives 0999; after 4 more cycles 0998.
3. Expiry: load 16'h0003, start -> count 0002, 0001, then 0000 with done_pulse=1 for exactly one cycle at cycle 12; expired=1 from cycle 13 onward; start in EXPIRED ignored; stop -> IDLE.
4. Pause/resume: load 0050, start, stop at cycle 6 (count 0049, prescaler=2), hold 20 cycles -> count stays 0049; start -> 0048 after 2 more cycles.
5. Priority/sanitize: load=stop=start=1 with preset 16'h0A0F -> count 0909, state LOADED, running=0; load 0000 then start -> remains IDLE, no done_pulse.
6. Reset mid-run: load 9999, start, rst at cycle 9 -> next cycle count 0000, IDLE, no done_pulse; subsequent start without load ignored.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// State encoding, digit limit and preset sanitization.
package countdown_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOADED  = 3'd1,
        RUNNING = 3'd2,
        PAUSED  = 3'd3,
        EXPIRED = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // Clamp a single BCD digit into 0..9.
    function automatic logic [3:0] sat_digit(input logic [3:0] d);
        return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
    endfunction

    // Clamp every digit of a 4-digit BCD word.
    function automatic logic [15:0] sanitize(input logic [15:0] p);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = sat_digit(p[4*i +: 4]);
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Command/status bundle of the countdown timer.
// master drives load/start/stop/preset; slave returns count and status.
interface countdown_timer_if #(
    parameter int PRESET_W = 16
);
    logic                load;
    logic                start;
    logic                stop;
    logic [PRESET_W-1:0] preset;
    logic [PRESET_W-1:0] count_bcd;
    logic                running;
    logic                expired;
    logic                done_pulse;

    modport master (
        output load, start, stop, preset,
        input  count_bcd, running, expired, done_pulse
    );

    modport slave (
        input  load, start, stop, preset,
        output count_bcd, running, expired, done_pulse
    );
endinterface

// File: rtl/countdown_timer_bcd_digit_down.sv
// One BCD decade down-counter: 0 wraps to 9 and raises borrow_out.
// Ports: clk, rst, dec_en, load, load_val[3:0] -> q[3:0], borrow_out.
module bcd_digit_down (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_en,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] q,
    output logic       borrow_out
);
    assign borrow_out = dec_en & (q == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 4'd0;
        end else if (load) begin
            q <= load_val;
        end else if (dec_en) begin
            q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
        end
    end
endmodule

// File: rtl/countdown_timer.sv
// BCD countdown timer in 0.01 s ticks with done pulse and expired flag.
// Ports: clk, rst, bus (slave: load/start/stop/preset -> count/status).
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int CLK_PER_TICK = 100000,
    parameter int PRESET_W     = 16
) (
    input logic               clk,
    input logic               rst,
    countdown_timer_if.slave  bus
);
    localparam int NDIG = PRESET_W / 4;
    localparam int PW   = $clog2(CLK_PER_TICK);
    localparam logic [PW-1:0] LAST = PW'(CLK_PER_TICK - 1);

    state_t              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                done_q, done_d;
    logic                tick;
    logic [PRESET_W-1:0] count;
    logic [PRESET_W-1:0] ld_val;
    logic [NDIG:0]       dec;

    assign ld_val = sanitize(bus.preset);
    assign dec[0] = tick;

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        bcd_digit_down u_dig (
            .clk        (clk),
            .rst        (rst),
            .dec_en     (dec[i]),
            .load       (bus.load),
            .load_val   (ld_val[4*i +: 4]),
            .q          (count[4*i +: 4]),
            .borrow_out (dec[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    // Command priority is load > stop > start; ticks only when no command.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        tick    = 1'b0;
        if (bus.load) begin
            presc_d = '0;
            state_d = (ld_val != '0) ? LOADED : IDLE;
        end else if (bus.stop) begin
            case (state_q)
                RUNNING: state_d = PAUSED;
                EXPIRED: state_d = IDLE;
                default: state_d = state_q;
            endcase
        end else if (bus.start) begin
            case (state_q)
                LOADED: begin
                    state_d = RUNNING;
                    presc_d = '0;
                end
                PAUSED:  state_d = RUNNING;
                default: state_d = state_q;
            endcase
        end else if (state_q == RUNNING) begin
            if (presc_q == LAST) begin
                presc_d = '0;
                // Guard keeps the borrow chain from wrapping below zero.
                tick = (count != '0);
                if (count == PRESET_W'(1)) begin
                    state_d = EXPIRED;
                    done_d  = 1'b1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // expired is held off during the done cycle so it rises one cycle later.
    assign bus.count_bcd  = count;
    assign bus.running    = (state_q == RUNNING);
    assign bus.expired    = (state_q == EXPIRED) & ~done_q;
    assign bus.done_pulse = done_q;
endmodule
